// File: rtl/qpd_multi_trigger_if.sv
// qpd_multi_trigger_if: register-bank side controls and front-end trigger outputs for qpd_multi_trigger.
interface qpd_multi_trigger_if #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int PULSE_W = 8
);
    logic                        run;
    logic [NUM_CH-1:0]           arm;
    logic [NUM_CH-1:0]           stop;
    logic [NUM_CH-1:0]           periodic;
    logic [NUM_CH*CNT_W-1:0]     delay;
    logic [NUM_CH*PULSE_W-1:0]   pulse_len;
    logic                        clr_err;
    logic [NUM_CH-1:0]           trigger;
    logic [NUM_CH-1:0]           busy;
    logic [NUM_CH-1:0]           done;
    logic [NUM_CH-1:0]           overrun;
    modport master (
        output run, arm, stop, periodic, delay, pulse_len, clr_err,
        input  trigger, busy, done, overrun
    );
    modport slave (
        input  run, arm, stop, periodic, delay, pulse_len, clr_err,
        output trigger, busy, done, overrun
    );
endinterface

// File: rtl/qpd_multi_trigger.sv
// qpd_multi_trigger: NUM_CH independent delayed trigger generators, one-shot or periodic.
// Optional TRIG_AUTOREARM_EN: a delay value differing from the last accepted one re-arms an idle channel.
module qpd_multi_trigger #(
    parameter int NUM_CH           = 4,
    parameter int CNT_W            = 16,
    parameter int PULSE_W          = 8,
    parameter int SAMPLE_FREQUENCY = 100000
) (
    input logic                sclock,
    input logic                rst,
    qpd_multi_trigger_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COUNT, PULSE} state_t;

    if (SAMPLE_FREQUENCY <= 0) begin : g_bad_freq
        $error("SAMPLE_FREQUENCY must be positive");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t             r_state, w_nstate;
        logic [CNT_W-1:0]   r_cnt, w_ncnt, r_sdelay, w_delay;
        logic [PULSE_W-1:0] r_pcnt, w_npcnt, r_slen, w_len;
        logic               r_sper, r_done, w_ndone, r_ovr, w_start;
        assign w_delay = bus.delay[i*CNT_W +: CNT_W];
        assign w_len   = (r_slen == '0) ? PULSE_W'(1) : r_slen;
`ifdef TRIG_AUTOREARM_EN
        logic [CNT_W-1:0] r_last;
        assign w_start = bus.run && !bus.stop[i] && r_state == IDLE && (bus.arm[i] || w_delay != r_last);
        always_ff @(posedge sclock) begin
            if (rst) r_last <= '0;
            else if (w_start) r_last <= w_delay;
        end
`else
        assign w_start = bus.run && !bus.stop[i] && r_state == IDLE && bus.arm[i];
`endif
        always_comb begin
            w_nstate = r_state;
            w_ncnt   = r_cnt;
            w_npcnt  = r_pcnt;
            w_ndone  = 1'b0;
            if (!bus.run || bus.stop[i]) begin
                w_nstate = IDLE;
            end else if (r_state == IDLE) begin
                w_nstate = w_start ? COUNT : IDLE;
                w_ncnt   = '0;
            end else if (r_state == COUNT) begin
                w_nstate = (r_cnt == r_sdelay) ? PULSE : COUNT;
                w_npcnt  = PULSE_W'(1);
                w_ncnt   = (r_cnt == r_sdelay) ? r_cnt : r_cnt + CNT_W'(1);
            end else if (r_pcnt == w_len) begin
                w_nstate = r_sper ? COUNT : IDLE;
                w_ncnt   = '0;
                w_ndone  = !r_sper;
            end else begin
                w_npcnt = r_pcnt + PULSE_W'(1);
            end
        end
        always_ff @(posedge sclock) begin
            if (rst) begin
                r_state  <= IDLE;
                r_cnt    <= '0;
                r_pcnt   <= '0;
                r_sdelay <= '0;
                r_slen   <= '0;
                r_sper   <= 1'b0;
                r_done   <= 1'b0;
                r_ovr    <= 1'b0;
            end else begin
                r_state <= w_nstate;
                r_cnt   <= w_ncnt;
                r_pcnt  <= w_npcnt;
                r_done  <= w_ndone;
                // a fresh overrun in the same cycle as clr_err must survive
                r_ovr   <= (bus.arm[i] && bus.run && r_state != IDLE) || (r_ovr && !bus.clr_err);
                if (w_start) begin
                    r_sdelay <= w_delay;
                    r_slen   <= bus.pulse_len[i*PULSE_W +: PULSE_W];
                    r_sper   <= bus.periodic[i];
                end
            end
        end
        assign bus.trigger[i] = (r_state == PULSE);
        assign bus.busy[i]    = (r_state != IDLE);
        assign bus.done[i]    = r_done;
        assign bus.overrun[i] = r_ovr;
    end
endmodule
